// File: rtl/btn_pkg.sv
// Shared definitions for the push-button input path: debounce state
// encoding, default timing constants and a counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } db_state_e;

  // 1 ms debounce tick at 100 MHz, and a 20 ms stability window.
  localparam int unsigned TICK_DIV_1MS       = 100_000;
  localparam int unsigned DEBOUNCE_TICKS_DEF = 20;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchronizer, four-state debounce FSM with a
// tick-based stability counter, and a registered one-cycle press pulse.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic CLK100MHZ,
  input  logic RESET,
  input  logic btn_i,
  input  logic tick_i,
  output logic pulse_o,
  output logic level_o
);

  localparam int unsigned     CW   = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          sync1_q, sync2_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // State, stability counter and pulse registers.
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Next state: a level change always beats a tick arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync2_q) begin
          state_d = RELEASED;
        end else if (tick_i) begin
          if (cnt_q == LAST) begin
            state_d = PRESSED;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (sync2_q) begin
          state_d = PRESSED;
        end else if (tick_i) begin
          if (cnt_q == LAST) begin
            state_d = RELEASED;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign pulse_o = pulse_q;
  assign level_o = (state_q == PRESSED) || (state_q == RELEASE_CHK);

endmodule

// File: rtl/btn_updown_counter.sv
// Lab top: two debounced push-buttons step an up/down count shown on LED.
module btn_updown_counter
  import btn_pkg::*;
#(
  parameter int unsigned TICK_DIV       = TICK_DIV_1MS,
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int unsigned WIDTH          = 8
) (
  input  logic             CLK100MHZ,
  input  logic             RESET,
  input  logic             BTNU,
  input  logic             BTND,
  output logic [WIDTH-1:0] LED,
  output logic             up_pulse,
  output logic             down_pulse
);

  localparam int unsigned   DW       = cnt_width(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0]    div_q, div_d;
  logic             tick;
  logic [WIDTH-1:0] led_q, led_d;
  logic             lvl_up_unused, lvl_dn_unused;

  // Debounce tick: high for the single cycle in which the divider is at its top.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DW'(1);
  end

  // Tick divider register.
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  btn_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_btnu (
    .CLK100MHZ(CLK100MHZ),
    .RESET    (RESET),
    .btn_i    (BTNU),
    .tick_i   (tick),
    .pulse_o  (up_pulse),
    .level_o  (lvl_up_unused)
  );

  btn_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_btnd (
    .CLK100MHZ(CLK100MHZ),
    .RESET    (RESET),
    .btn_i    (BTND),
    .tick_i   (tick),
    .pulse_o  (down_pulse),
    .level_o  (lvl_dn_unused)
  );

  // Count step: simultaneous up and down cancel; wraps modulo 2^WIDTH.
  always_comb begin
    led_d = led_q;
    if (up_pulse && !down_pulse) begin
      led_d = led_q + WIDTH'(1);
    end else if (down_pulse && !up_pulse) begin
      led_d = led_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_btn_updown_counter.sv
// Self-checking bench for btn_updown_counter with a run-length reference model.
module tb_btn_updown_counter;

  localparam int TD = 10;
  localparam int DT = 4;

  logic       CLK100MHZ = 1'b0;
  logic       RESET     = 1'b1;
  logic       BTNU      = 1'b0;
  logic       BTND      = 1'b0;
  logic [7:0] LED;
  logic       up_pulse, down_pulse;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    bit r;
    bit u;
    bit d;
    int len;
  } phase_t;

  btn_updown_counter #(
    .TICK_DIV      (TD),
    .DEBOUNCE_TICKS(DT),
    .WIDTH         (8)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .RESET     (RESET),
    .BTNU      (BTNU),
    .BTND      (BTND),
    .LED       (LED),
    .up_pulse  (up_pulse),
    .down_pulse(down_pulse)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // Reference model: a button's accepted level flips once the synchronized
  // input has disagreed with it without interruption for DT whole ticks,
  // counting only ticks after the first disagreeing cycle.
  logic [7:0] m_led = 8'd0;
  bit         m_up = 1'b0, m_dn = 1'b0;
  bit         h1[2], h2[2], lvl[2], mis[2];
  int         tk[2];
  int         n = 0;

  initial begin
    forever begin
      @(posedge CLK100MHZ);
      if (RESET) begin
        m_led = 8'd0; m_up = 1'b0; m_dn = 1'b0; n = 0;
        for (int b = 0; b < 2; b++) begin
          h1[b] = 1'b0; h2[b] = 1'b0; lvl[b] = 1'b0; mis[b] = 1'b0; tk[b] = 0;
        end
      end else begin
        bit raw[2];
        bit pul[2];
        bit tick;
        bit seen;
        raw[0] = BTNU; raw[1] = BTND;
        tick = ((n % TD) == TD - 1);
        n++;
        m_led = m_led + {7'd0, m_up} - {7'd0, m_dn};
        for (int b = 0; b < 2; b++) begin
          pul[b] = 1'b0;
          seen   = h2[b];
          h2[b]  = h1[b];
          h1[b]  = raw[b];
          if (seen == lvl[b]) begin
            mis[b] = 1'b0; tk[b] = 0;
          end else if (!mis[b]) begin
            mis[b] = 1'b1;
          end else if (tick) begin
            tk[b]++;
            if (tk[b] == DT) begin
              lvl[b] = seen; mis[b] = 1'b0; tk[b] = 0; pul[b] = seen;
            end
          end
        end
        m_up = pul[0];
        m_dn = pul[1];
      end
    end
  end

  task automatic test_reset();
    RESET = 1'b1; BTNU = 1'b1; BTND = 1'b1;
    repeat (3) @(negedge CLK100MHZ);
    nchk++;
    if (LED !== 8'd0) begin nerr++; $display("FAIL reset_led: LED=%0d expected 0", LED); end
    nchk++;
    if (up_pulse !== 1'b0 || down_pulse !== 1'b0) begin
      nerr++; $display("FAIL reset_pulses: up=%b dn=%b expected 0 0", up_pulse, down_pulse);
    end
    nchk++;
    if (dut.u_btnu.level_o !== 1'b0) begin
      nerr++; $display("FAIL reset_level: level=%b expected 0", dut.u_btnu.level_o);
    end
    BTNU = 1'b0; BTND = 1'b0;
  endtask

  task automatic test_single_press();
    phase_t ph[$];
    int nup = 0, first = -1, edges = 0;
    ph.push_back('{1, 0, 0, 3});
    ph.push_back('{0, 1, 0, 200});
    ph.push_back('{0, 0, 0, 60});
    foreach (ph[p]) begin
      RESET = ph[p].r; BTNU = ph[p].u; BTND = ph[p].d;
      for (int i = 0; i < ph[p].len; i++) begin
        @(negedge CLK100MHZ);
        if (p == 1) edges++;
        nchk++;
        if (LED !== m_led || up_pulse !== m_up || down_pulse !== m_dn) begin
          nerr++;
          $display("FAIL single_press p%0d c%0d: LED=%0d up=%b dn=%b, expected LED=%0d up=%b dn=%b",
                   p, i, LED, up_pulse, down_pulse, m_led, m_up, m_dn);
        end
        if (up_pulse === 1'b1) begin
          nup++;
          if (first < 0 && p == 1) first = edges;
        end
      end
    end
    nchk++;
    if (nup != 1) begin nerr++; $display("FAIL single_press_count: pulses=%0d expected 1", nup); end
    nchk++;
    if (first < 30 || first > 45) begin
      nerr++; $display("FAIL single_press_latency: %0d cycles expected 30..45", first);
    end
    nchk++;
    if (LED !== 8'd1) begin nerr++; $display("FAIL single_press_led: LED=%0d expected 1", LED); end
  endtask

  task automatic test_bounce();
    phase_t ph[$];
    int nup = 0;
    ph.push_back('{1, 0, 0, 3});
    for (int k = 0; k < 5; k++) begin
      ph.push_back('{0, 1, 0, 7});
      ph.push_back('{0, 0, 0, 7});
    end
    ph.push_back('{0, 0, 0, 60});
    foreach (ph[p]) begin
      RESET = ph[p].r; BTNU = ph[p].u; BTND = ph[p].d;
      for (int i = 0; i < ph[p].len; i++) begin
        @(negedge CLK100MHZ);
        nchk++;
        if (LED !== m_led || up_pulse !== m_up || down_pulse !== m_dn) begin
          nerr++;
          $display("FAIL bounce p%0d c%0d: LED=%0d up=%b dn=%b, expected LED=%0d up=%b dn=%b",
                   p, i, LED, up_pulse, down_pulse, m_led, m_up, m_dn);
        end
        if (up_pulse === 1'b1) nup++;
      end
    end
    nchk++;
    if (nup != 0) begin nerr++; $display("FAIL bounce_count: pulses=%0d expected 0", nup); end
    nchk++;
    if (LED !== 8'd0) begin nerr++; $display("FAIL bounce_led: LED=%0d expected 0", LED); end
    nchk++;
    if (dut.u_btnu.level_o !== 1'b0) begin
      nerr++; $display("FAIL bounce_level: level=%b expected 0", dut.u_btnu.level_o);
    end
  endtask

  task automatic test_wrap();
    phase_t ph[$];
    logic [7:0] led_end[$];
    ph.push_back('{1, 0, 0, 3});
    ph.push_back('{0, 0, 1, 60});
    ph.push_back('{0, 0, 0, 60});
    ph.push_back('{0, 1, 0, 60});
    ph.push_back('{0, 0, 0, 60});
    foreach (ph[p]) begin
      RESET = ph[p].r; BTNU = ph[p].u; BTND = ph[p].d;
      for (int i = 0; i < ph[p].len; i++) begin
        @(negedge CLK100MHZ);
        nchk++;
        if (LED !== m_led || up_pulse !== m_up || down_pulse !== m_dn) begin
          nerr++;
          $display("FAIL wrap p%0d c%0d: LED=%0d up=%b dn=%b, expected LED=%0d up=%b dn=%b",
                   p, i, LED, up_pulse, down_pulse, m_led, m_up, m_dn);
        end
      end
      led_end.push_back(LED);
    end
    nchk++;
    if (led_end[2] !== 8'd255) begin nerr++; $display("FAIL wrap_down: LED=%0d expected 255", led_end[2]); end
    nchk++;
    if (led_end[4] !== 8'd0) begin nerr++; $display("FAIL wrap_up: LED=%0d expected 0", led_end[4]); end
  endtask

  task automatic test_simultaneous();
    phase_t ph[$];
    int nup = 0, ndn = 0;
    ph.push_back('{1, 0, 0, 3});
    ph.push_back('{0, 1, 1, 80});
    foreach (ph[p]) begin
      RESET = ph[p].r; BTNU = ph[p].u; BTND = ph[p].d;
      for (int i = 0; i < ph[p].len; i++) begin
        @(negedge CLK100MHZ);
        nchk++;
        if (LED !== m_led || up_pulse !== m_up || down_pulse !== m_dn) begin
          nerr++;
          $display("FAIL simultaneous p%0d c%0d: LED=%0d up=%b dn=%b, expected LED=%0d up=%b dn=%b",
                   p, i, LED, up_pulse, down_pulse, m_led, m_up, m_dn);
        end
        nchk++;
        if (up_pulse !== down_pulse) begin
          nerr++; $display("FAIL simultaneous_coincide c%0d: up=%b dn=%b expected equal", i, up_pulse, down_pulse);
        end
        if (up_pulse === 1'b1) nup++;
        if (down_pulse === 1'b1) ndn++;
      end
    end
    nchk++;
    if (nup != 1 || ndn != 1) begin
      nerr++; $display("FAIL simultaneous_count: up=%0d dn=%0d expected 1 1", nup, ndn);
    end
    nchk++;
    if (LED !== 8'd0) begin nerr++; $display("FAIL simultaneous_led: LED=%0d expected 0", LED); end
  endtask

  task automatic test_reset_midpress();
    phase_t ph[$];
    int pu[$];
    ph.push_back('{1, 0, 0, 3});
    ph.push_back('{0, 1, 0, 15});
    ph.push_back('{1, 1, 0, 1});
    ph.push_back('{0, 1, 0, 100});
    ph.push_back('{0, 0, 0, 50});
    foreach (ph[p]) begin
      int cnt = 0;
      RESET = ph[p].r; BTNU = ph[p].u; BTND = ph[p].d;
      for (int i = 0; i < ph[p].len; i++) begin
        @(negedge CLK100MHZ);
        nchk++;
        if (LED !== m_led || up_pulse !== m_up || down_pulse !== m_dn) begin
          nerr++;
          $display("FAIL reset_midpress p%0d c%0d: LED=%0d up=%b dn=%b, expected LED=%0d up=%b dn=%b",
                   p, i, LED, up_pulse, down_pulse, m_led, m_up, m_dn);
        end
        if (up_pulse === 1'b1) cnt++;
      end
      pu.push_back(cnt);
    end
    nchk++;
    if (pu[1] != 0 || pu[2] != 0) begin
      nerr++; $display("FAIL reset_midpress_early: pulses=%0d expected 0", pu[1] + pu[2]);
    end
    nchk++;
    if (pu[3] != 1) begin nerr++; $display("FAIL reset_midpress_after: pulses=%0d expected 1", pu[3]); end
    nchk++;
    if (LED !== 8'd1) begin nerr++; $display("FAIL reset_midpress_led: LED=%0d expected 1", LED); end
  endtask

  task automatic test_back_to_back();
    phase_t ph[$];
    int nup = 0;
    ph.push_back('{1, 0, 0, 3});
    ph.push_back('{0, 1, 0, 500});
    ph.push_back('{0, 0, 0, int'($urandom_range(5, 20))});
    ph.push_back('{0, 1, 0, int'($urandom_range(5, 20))});
    ph.push_back('{0, 0, 0, 100});
    ph.push_back('{0, 1, 0, int'($urandom_range(3, 20))});
    ph.push_back('{0, 0, 0, 60});
    ph.push_back('{0, 1, 0, 200});
    foreach (ph[p]) begin
      RESET = ph[p].r; BTNU = ph[p].u; BTND = ph[p].d;
      for (int i = 0; i < ph[p].len; i++) begin
        @(negedge CLK100MHZ);
        nchk++;
        if (LED !== m_led || up_pulse !== m_up || down_pulse !== m_dn) begin
          nerr++;
          $display("FAIL back_to_back p%0d c%0d: LED=%0d up=%b dn=%b, expected LED=%0d up=%b dn=%b",
                   p, i, LED, up_pulse, down_pulse, m_led, m_up, m_dn);
        end
        if (up_pulse === 1'b1) nup++;
      end
    end
    nchk++;
    if (nup != 2) begin nerr++; $display("FAIL back_to_back_count: pulses=%0d expected 2", nup); end
    nchk++;
    if (LED !== 8'd2) begin nerr++; $display("FAIL back_to_back_led: LED=%0d expected 2", LED); end
  endtask

  task automatic test_random();
    phase_t ph[$];
    ph.push_back('{1, 0, 0, 3});
    for (int k = 0; k < 80; k++) begin
      ph.push_back('{0, 1'($urandom), 1'($urandom), int'($urandom_range(1, 60))});
    end
    ph.push_back('{0, 0, 0, 60});
    foreach (ph[p]) begin
      RESET = ph[p].r; BTNU = ph[p].u; BTND = ph[p].d;
      for (int i = 0; i < ph[p].len; i++) begin
        @(negedge CLK100MHZ);
        nchk++;
        if (LED !== m_led || up_pulse !== m_up || down_pulse !== m_dn) begin
          nerr++;
          $display("FAIL random p%0d c%0d: LED=%0d up=%b dn=%b, expected LED=%0d up=%b dn=%b",
                   p, i, LED, up_pulse, down_pulse, m_led, m_up, m_dn);
        end
        nchk++;
        if (dut.u_btnu.level_o !== lvl[0] || dut.u_btnd.level_o !== lvl[1]) begin
          nerr++;
          $display("FAIL random_level p%0d c%0d: u=%b d=%b expected u=%b d=%b", p, i,
                   dut.u_btnu.level_o, dut.u_btnd.level_o, lvl[0], lvl[1]);
        end
      end
    end
  endtask

  initial begin
    @(negedge CLK100MHZ);
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_simultaneous();
    test_reset_midpress();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
